mult_arbiter: RTL and testbench
===============================

// Module: mult_arbiter
// PURPOSE
//  Shares one 8x8 signed add-shift multiplier core (register unit + multiply control FSM) among
//  NREQ requesters. Round-robin grant, sequences the core's load-B / run / release protocol, and
//  returns a registered 16-bit product with a one-cycle ack. Guards against a hung core with a timeout.
// PARAMETERS
//  NREQ     2   number of requesters (2..4)
//  TIMEOUT  64  max WAIT cycles for mul_done before aborting with err
// PORTS
//  Clk          in   1          system clock, all state on rising edge
//  Reset        in   1          asynchronous, active-low reset
//  req          in   NREQ       per-requester request level; held with operands until own ack
//  op_a         in   8*NREQ     multiplicand per requester (signed), slot i = [8i+7:8i]
//  op_b         in   8*NREQ     multiplier per requester (signed)
//  grant        out  NREQ       one-hot, requester currently owning the core
//  ack          out  NREQ       one-cycle pulse to owner when product/err valid
//  product      out  16         signed A*B, registered, holds until next ack
//  err          out  1          valid with ack; 1 = timeout abort, product not updated
//  mul_s        out  8          operand bus to core switch input
//  mul_clr_ld   out  1          core ClearA_LoadB strobe (loads B from mul_s, clears A)
//  mul_run      out  1          core Run level
//  mul_done     in   1          core finished (high while core in its HALT state)
//  mul_product  in   16         core {A,B} result
// BEHAVIOUR
//  Reset (async, Reset=0): state IDLE, grant=0, ack=0, product=0, err=0, mul_s=0, mul_clr_ld=0,
//   mul_run=0, rr pointer=0, timer=0. Outputs go to reset values immediately, no clock needed.
//  States: IDLE, LOAD_B, RUN, WAIT, RELEASE, RESPOND.
//  IDLE: if |req, winner = first set req at or after pointer (wrapping); latch op_a/op_b of winner,
//   grant<=onehot(winner) -> LOAD_B. No req: stay.
//  LOAD_B (1 cycle): mul_s=B latched, mul_clr_ld=1 -> RUN.
//  RUN (1 cycle): mul_s=A latched, mul_run=1, timer<=0 -> WAIT.
//  WAIT: mul_run=1, mul_s=A. mul_done=1 -> product<=mul_product, err<=0 -> RELEASE.
//   Else timer++; timer==TIMEOUT-1 -> err<=1, product unchanged -> RELEASE. done wins on same cycle.
//  RELEASE: mul_run=0; stay until mul_done=0 (core leaves HALT) -> RESPOND. Timeout path proceeds
//   to RESPOND the cycle after entry regardless of mul_done.
//  RESPOND (1 cycle): ack[winner]=1, err valid; pointer<=(winner+1) mod NREQ; grant<=0 -> IDLE.
//  mul_clr_ld and mul_run never high in the same cycle; mul_clr_ld only in LOAD_B.
//  req changes outside IDLE are ignored; new/held reqs sampled only in IDLE (min 1 idle cycle
//   between jobs). Requester must drop req in the cycle after ack or it is re-served later.
//  Latency (no contention): req high in IDLE -> ack = 4 + (WAIT cycles) + (RELEASE cycles).
//  Arithmetic: all products two's complement 16 bit, taken verbatim from core; no re-signing.
//  Reset mid-job: job lost, no ack, core sees mul_run drop; requester must re-request.
// STRUCTURE
//  mult_arb_pkg: state enum (3-bit), OP_W=8, PROD_W=16, timer width $clog2(TIMEOUT).
//  Sub-module rr_pick: combinational round-robin picker (req, pointer -> onehot, index, any).
//  Top: FSM, operand/product registers, timer, pointer; mul_s mux registered per state.
// TESTING
//  1 req[0], A=8'h07, B=8'h03, core model done after 20 cycles -> single clr_ld pulse then run;
//    ack[0] once, product=16'h0015, err=0, grant=2'b01 throughout job.
//  2 req[1], A=8'hFE, B=8'h05 -> product=16'hFFF6; A=8'h80,B=8'h80 -> 16'h4000.
//  3 req=2'b11 from reset -> req0 served first, then req1; req0 re-asserted during req1's job
//    -> served after; continuous req=2'b11 alternates 0,1,0,1 acks.
//  4 core never raises mul_done -> ack with err=1 exactly TIMEOUT WAIT cycles after RUN;
//    product keeps previous value; next job completes normally.
//  5 Reset low during WAIT -> grant, mul_run, ack drop to 0 asynchronously; after release IDLE,
//    pointer=0, still-held req re-served with correct product.
//  6 mul_done held high 3 cycles after run drops -> RESPOND only after mul_done=0; ack width 1.

Source files
------------

// File: rtl/mult_arbiter_pkg.sv
// Shared types and widths for the multiplier-core arbiter.
//   state_t    : arbiter FSM states (3-bit encoding)
//   operands_t : one requester's {A, B} operand pair
//   cnt_w()    : counter/index width helper (never below 1 bit)
package mult_arbiter_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_RUN     = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_RESPOND = 3'd5
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } operands_t;

  // Width needed to count/index n distinct values, at least one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   i_req      : request vector
//   i_ptr      : index with highest priority this round
//   o_onehot_c : one-hot winner (zero when nothing requested)
//   o_idx_c    : binary index of the winner
//   o_any_c    : at least one request present
module mult_arbiter_rr_pick
  import mult_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = cnt_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot_c,
  output logic [PW-1:0]   o_idx_c,
  output logic            o_any_c
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_pos;

  // Walk the requesters starting at the pointer, wrapping; first hit wins.
  always_comb begin
    o_onehot_c = '0;
    o_idx_c    = '0;
    o_any_c    = 1'b0;
    w_sum      = '0;
    w_pos      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) begin
        w_sum = w_sum - (PW+1)'(NREQ);
      end
      w_pos = w_sum[PW-1:0];
      if (!o_any_c && i_req[w_pos]) begin
        o_any_c           = 1'b1;
        o_idx_c           = w_pos;
        o_onehot_c[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one 8x8 signed add-shift multiplier core among NREQ requesters.
// Round-robin grant, drives the core's load-B / run / release handshake,
// returns a registered 16-bit product with a one-cycle ack, and aborts
// with err if the core does not finish within TIMEOUT wait cycles.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_req            : per-requester request level, held until own ack
//   i_op_a, i_op_b   : signed operands, slot i = [8i+7:8i]
//   o_grant          : one-hot owner of the core
//   o_ack            : one-cycle pulse to owner when product/err valid
//   o_product        : last successful product, holds between acks
//   o_err            : valid with ack, 1 = timeout abort
//   o_mul_s          : operand bus to the core switch input
//   o_mul_clr_ld     : core ClearA_LoadB strobe
//   o_mul_run        : core Run level
//   i_mul_done       : core is in its HALT state
//   i_mul_product    : core {A,B} result
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NREQ-1:0]        i_req,
  input  logic [OP_W*NREQ-1:0]   i_op_a,
  input  logic [OP_W*NREQ-1:0]   i_op_b,
  output logic [NREQ-1:0]        o_grant,
  output logic [NREQ-1:0]        o_ack,
  output logic [PROD_W-1:0]      o_product,
  output logic                   o_err,
  output logic [OP_W-1:0]        o_mul_s,
  output logic                   o_mul_clr_ld,
  output logic                   o_mul_run,
  input  logic                   i_mul_done,
  input  logic [PROD_W-1:0]      i_mul_product
);

  localparam int unsigned PW = cnt_w(NREQ);
  localparam int unsigned TW = cnt_w(TIMEOUT);

  state_t              r_state;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_win;
  logic [OP_W-1:0]     r_op_a;
  logic [TW-1:0]       r_timer;
  logic [NREQ-1:0]     r_grant;
  logic [NREQ-1:0]     r_ack;
  logic [PROD_W-1:0]   r_product;
  logic                r_err;
  logic [OP_W-1:0]     r_mul_s;
  logic                r_clr_ld;
  logic                r_run;

  operands_t           w_ops [NREQ];
  operands_t           w_sel;
  logic [NREQ-1:0]     w_pick_onehot;
  logic [PW-1:0]       w_pick_idx;
  logic                w_pick_any;
  logic [PW-1:0]       w_ptr_next;

  // Unpack the flat operand buses into per-requester pairs.
  for (genvar g = 0; g < NREQ; g++) begin : g_ops
    assign w_ops[g].a = i_op_a[g*OP_W +: OP_W];
    assign w_ops[g].b = i_op_b[g*OP_W +: OP_W];
  end

  mult_arbiter_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .i_req      (i_req),
    .i_ptr      (r_ptr),
    .o_onehot_c (w_pick_onehot),
    .o_idx_c    (w_pick_idx),
    .o_any_c    (w_pick_any)
  );

  assign w_sel      = w_ops[w_pick_idx];
  assign w_ptr_next = (r_win == PW'(NREQ-1)) ? '0 : r_win + PW'(1);

  // Arbiter FSM; every core-facing and requester-facing output is a register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_win     <= '0;
      r_op_a    <= '0;
      r_timer   <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_product <= '0;
      r_err     <= 1'b0;
      r_mul_s   <= '0;
      r_clr_ld  <= 1'b0;
      r_run     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_win    <= w_pick_idx;
            r_op_a   <= w_sel.a;
            r_grant  <= w_pick_onehot;
            r_mul_s  <= w_sel.b;
            r_clr_ld <= 1'b1;
            r_state  <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          r_clr_ld <= 1'b0;
          r_mul_s  <= r_op_a;
          r_run    <= 1'b1;
          r_state  <= ST_RUN;
        end
        ST_RUN: begin
          r_timer <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done seen on the last allowed cycle still counts as success.
          if (i_mul_done) begin
            r_product <= i_mul_product;
            r_err     <= 1'b0;
            r_run     <= 1'b0;
            r_state   <= ST_RELEASE;
          end else if (r_timer == TW'(TIMEOUT-1)) begin
            r_err   <= 1'b1;
            r_run   <= 1'b0;
            r_state <= ST_RELEASE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_RELEASE: begin
          // Wait for the core to leave HALT, except after an abort.
          if (r_err || !i_mul_done) begin
            r_ack   <= r_grant;
            r_state <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          r_ack   <= '0;
          r_grant <= '0;
          r_ptr   <= w_ptr_next;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ack    <= '0;
          r_grant  <= '0;
          r_clr_ld <= 1'b0;
          r_run    <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_grant      = r_grant;
  assign o_ack        = r_ack;
  assign o_product    = r_product;
  assign o_err        = r_err;
  assign o_mul_s      = r_mul_s;
  assign o_mul_clr_ld = r_clr_ld;
  assign o_mul_run    = r_run;

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 64;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req   = '0;
  logic [15:0] op_a  = '0;
  logic [15:0] op_b  = '0;
  logic [1:0]  grant, ack;
  logic [15:0] product;
  logic        err;
  logic [7:0]  mul_s;
  logic        clr, run;
  logic        done  = 1'b0;
  logic [15:0] mprod = '0;

  always #5 clk = ~clk;

  mult_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req         (req),
    .i_op_a        (op_a),
    .i_op_b        (op_b),
    .o_grant       (grant),
    .o_ack         (ack),
    .o_product     (product),
    .o_err         (err),
    .o_mul_s       (mul_s),
    .o_mul_clr_ld  (clr),
    .o_mul_run     (run),
    .i_mul_done    (done),
    .i_mul_product (mprod)
  );

  // ---------------- multiplier core model (shift-add) ----------------
  int         core_delay = 20;
  int         core_hold  = 1;
  bit         core_hang  = 0;
  logic [7:0] c_a = '0, c_b = '0;
  logic       c_busy = 1'b0, c_prev_run = 1'b0;
  int         c_cnt = 0, c_hcnt = 0;

  function automatic logic [15:0] core_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ae, p;
    ae = {{8{a[7]}}, a};
    p  = '0;
    for (int i = 0; i < 7; i++) if (b[i]) p = p + (ae << i);
    if (b[7]) p = p - (ae << 7);
    return p;
  endfunction

  always @(posedge clk) begin
    c_prev_run <= run;
    if (clr) c_b <= mul_s;
    if (run && !c_prev_run) begin
      c_a <= mul_s; c_cnt <= 0; c_busy <= 1'b1;
    end else if (c_busy) begin
      if (!run) c_busy <= 1'b0;
      else if (!core_hang && c_cnt >= core_delay - 1) begin
        c_busy <= 1'b0; done <= 1'b1; mprod <= core_mul(c_a, c_b); c_hcnt <= 0;
      end else c_cnt <= c_cnt + 1;
    end
    if (done && !run) begin
      if (c_hcnt >= core_hold - 1) begin done <= 1'b0; c_hcnt <= 0; end
      else c_hcnt <= c_hcnt + 1;
    end
  end

  // ---------------- protocol invariants ----------------
  int viol = 0;
  always @(negedge clk) if (rst_n) begin
    if (clr && run) viol++;
    if ($countones(grant) > 1) viol++;
    if (ack != 0 && ack != grant) viol++;
    if (clr && grant == 0) viol++;
  end

  // ---------------- reference model & checking ----------------
  int          n_pass = 0, n_total = 0;
  int          m_ptr  = 0;
  logic [15:0] m_prod = '0;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return 16'(p);
  endfunction

  function automatic int pick(input logic [1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  bit          ob_got;
  logic [1:0]  ob_ack;
  logic        ob_err;
  logic [15:0] ob_prod;
  logic [7:0]  ob_s_clr, ob_s_run;
  bit          ob_saw_run;
  int          ob_clr_cnt, ob_rel_done, ob_grant_bad, ob_first_clr, ob_last_done, ob_ack_cyc;

  task automatic wait_ack(input int budget, input logic [1:0] exp_grant);
    ob_got = 0; ob_clr_cnt = 0; ob_rel_done = 0; ob_grant_bad = 0;
    ob_first_clr = -1; ob_last_done = -1; ob_ack_cyc = -1; ob_saw_run = 0;
    ob_s_clr = '0; ob_s_run = '0;
    for (int c = 1; c <= budget && !ob_got; c++) begin
      @(negedge clk);
      if (clr) begin
        ob_clr_cnt++;
        if (ob_first_clr < 0) begin ob_first_clr = c; ob_s_clr = mul_s; end
      end
      if (run && !ob_saw_run) begin ob_saw_run = 1; ob_s_run = mul_s; end
      if ((grant != 0 || ob_first_clr >= 0) && grant != exp_grant) ob_grant_bad++;
      if (grant != 0 && !run && done) ob_rel_done++;
      if (done) ob_last_done = c;
      if (ack != 0) begin
        ob_got = 1; ob_ack_cyc = c; ob_ack = ack; ob_err = err; ob_prod = product;
      end
    end
  endtask

  // Serve one job: predict winner/product, wait for ack, check, optionally drop req.
  task automatic do_job(input string tag, input bit drop, input bit exp_err, input bit full);
    int w;
    logic [1:0] oh;
    logic [7:0] a, b;
    logic [15:0] ep;
    w = pick(req, m_ptr);
    if (w < 0) begin
      n_total++;
      $display("FAIL %s: no request to serve, got none expected one", tag);
      return;
    end
    oh = 2'(1 << w);
    a  = op_a[w*8 +: 8];
    b  = op_b[w*8 +: 8];
    ep = exp_err ? m_prod : ref_mul(a, b);
    wait_ack(TIMEOUT + 200, oh);
    chk({tag, "_ack_seen"}, 32'(ob_got), 1);
    if (!ob_got) return;
    chk({tag, "_ack"}, 32'(ob_ack), 32'(oh));
    chk({tag, "_err"}, 32'(ob_err), 32'(exp_err));
    chk({tag, "_prod"}, 32'(ob_prod), 32'(ep));
    chk({tag, "_grant"}, 32'(ob_grant_bad), 0);
    if (full) begin
      chk({tag, "_clr_cnt"}, 32'(ob_clr_cnt), 1);
      chk({tag, "_s_b"}, 32'(ob_s_clr), 32'(b));
      chk({tag, "_s_a"}, 32'(ob_s_run), 32'(a));
    end
    m_prod = ep;
    m_ptr  = (w + 1) % NREQ;
    if (drop) req[w] = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_width"}, 32'(ack), 0);
    chk({tag, "_grant_off"}, 32'(grant), 0);
  endtask

  task automatic wait_grant(input logic [1:0] g, input string tag);
    bit ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (grant == g) ok = 1;
    end
    chk({tag, "_grant_wait"}, 32'(ok), 1);
  endtask

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rst_grant"}, 32'(grant), 0);
    chk({tag, "_rst_ack"}, 32'(ack), 0);
    chk({tag, "_rst_run_clr"}, 32'({run, clr}), 0);
    chk({tag, "_rst_prod_err"}, 32'({err, product}), 0);
    chk({tag, "_rst_s"}, 32'(mul_s), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    m_ptr  = 0;
    m_prod = '0;
  endtask

  task automatic set_ops(input int j, input logic [7:0] a, input logic [7:0] b);
    op_a[j*8 +: 8] = a;
    op_b[j*8 +: 8] = b;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [7:0]  a;
    logic [7:0]  b;
    int          delay;
    logic [15:0] exp_prod;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'b01, 8'h07, 8'h03, 20, 16'h0015};
    tbl[1] = '{2'b10, 8'hFE, 8'h05, 3,  16'hFFF6};
    tbl[2] = '{2'b10, 8'h80, 8'h80, 5,  16'h4000};
    tbl[3] = '{2'b01, 8'h7F, 8'h81, 2,  16'hC0FF};
    tbl[4] = '{2'b01, 8'hFF, 8'hFF, 1,  16'h0001};
    tbl[5] = '{2'b10, 8'h00, 8'h55, 4,  16'h0000};
    tbl[6] = '{2'b01, 8'h80, 8'h7F, 7,  16'hC080};
    tbl[7] = '{2'b10, 8'h0C, 8'hF6, 9,  16'hFF88};

    do_reset("por");

    // Directed single-requester vectors.
    for (int i = 0; i < 8; i++) begin
      core_delay = tbl[i].delay;
      core_hold  = 1;
      set_ops(tbl[i].req[1] ? 1 : 0, tbl[i].a, tbl[i].b);
      req = tbl[i].req;
      do_job($sformatf("tbl%0d", i), 1, 0, 1);
      chk($sformatf("tbl%0d_const", i), 32'(ob_prod), 32'(tbl[i].exp_prod));
    end

    // Done on the final allowed wait cycle succeeds; one cycle later aborts.
    core_delay = TIMEOUT - 1;
    set_ops(0, 8'h11, 8'h0D); req = 2'b01;
    do_job("done_last", 1, 0, 1);
    core_delay = TIMEOUT;
    set_ops(0, 8'h22, 8'h05); req = 2'b01;
    do_job("done_late", 1, 1, 1);

    // Hung core: abort after TIMEOUT wait cycles, product kept; then recover.
    core_hang = 1;
    set_ops(0, 8'h03, 8'h03); req = 2'b01;
    do_job("hang", 1, 1, 1);
    chk("hang_latency", 32'(ob_ack_cyc - ob_first_clr), 32'(TIMEOUT + 3));
    core_hang = 0; core_delay = 6;
    set_ops(0, 8'h05, 8'hFD); req = 2'b01;
    do_job("after_hang", 1, 0, 1);
    chk("after_hang_const", 32'(ob_prod), 32'h0000FFF1);

    // Contention from reset, re-request during another job, continuous alternation.
    do_reset("rr");
    core_delay = 5;
    set_ops(0, 8'h09, 8'hF9);
    set_ops(1, 8'hC3, 8'h21);
    req = 2'b11;
    do_job("rr_a", 1, 0, 1);
    chk("rr_a_first", 32'(ob_ack), 32'h1);
    wait_grant(2'b10, "rr_b");
    req[0] = 1'b1;
    do_job("rr_b", 1, 0, 0);
    chk("rr_b_second", 32'(ob_ack), 32'h2);
    do_job("rr_c", 1, 0, 1);
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      do_job($sformatf("alt%0d", i), 0, 0, 1);
      chk($sformatf("alt%0d_order", i), 32'(ob_ack), (i % 2 == 0) ? 32'h2 : 32'h1);
    end

    // Reset during WAIT: job lost, pointer back to 0, held requests re-served.
    core_delay = 30;
    wait_grant(2'b10, "mid");
    repeat (4) @(negedge clk);
    chk("mid_in_wait", 32'({run, grant}), 32'h6);
    do_reset("mid");
    core_delay = 4;
    do_job("mid_re0", 1, 0, 1);
    chk("mid_re0_owner", 32'(ob_ack), 32'h1);
    do_job("mid_re1", 1, 0, 1);

    // Core lingers in HALT for 3 cycles after run drops.
    core_delay = 4; core_hold = 3;
    set_ops(0, 8'h40, 8'h02); req = 2'b01;
    do_job("halt3", 1, 0, 1);
    chk("halt3_hold", 32'(ob_rel_done), 3);
    chk("halt3_after", 32'(ob_ack_cyc - ob_last_done), 2);
    core_hold = 1;

    // Randomized traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      core_delay = $urandom_range(1, 10);
      core_hold  = $urandom_range(1, 3);
      for (int j = 0; j < NREQ; j++) begin
        if (!req[j] && $urandom_range(0, 1) == 1) begin
          set_ops(j, 8'($urandom), 8'($urandom));
          req[j] = 1'b1;
        end
      end
      if (req == 2'b00) begin
        set_ops(0, 8'($urandom), 8'($urandom));
        req[0] = 1'b1;
      end
      do_job($sformatf("rnd%0d", it), 1, 0, 1);
    end

    chk("invariants", 32'(viol), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
